// File: rtl/mem_line_serializer.sv
// mem_line_serializer
//   Blocking line-to-word adapter between the cache and a word-wide memory.
//   One 128b line request is latched and issued as four 32b word requests.
//   The four in-order word responses are collected into a single line response.
//   The security domain is latched with the line and driven on o_mem_domain
//   until the line response is accepted.
//
//   Message layouts, MSB first:
//     line req  {type[2:0], opaque, addr, len[3:0], data[127:0]}  175b
//     line resp {type[2:0], opaque, len[3:0], data[127:0]}        143b
//     word req  {type[2:0], opaque, addr, len[1:0], data[31:0]}    77b
//     word resp {type[2:0], opaque, len[1:0], data[31:0]}          45b
//   Type encoding: 0 = read, 1 = write.
//
//   Optional build macro MEM_LINE_SERIALIZER_INSECURE_ZERO_EN:
//     Adds the i_memresp_insecure input.
//     If any word response of a line is flagged insecure, the line response
//     data is forced to zero. Type and opaque are left unchanged.
module mem_line_serializer #(
   parameter  int p_opaque_nbits    = 8,
   parameter  int p_addr_nbits      = 32,
   parameter  int p_line_nbits      = 128,
   parameter  int p_word_nbits      = 32,
   localparam int c_line_len_nbits  = $clog2(p_line_nbits / 8),
   localparam int c_word_len_nbits  = $clog2(p_word_nbits / 8),
   localparam int c_line_req_nbits  = 3 + p_opaque_nbits + p_addr_nbits + c_line_len_nbits + p_line_nbits,
   localparam int c_line_resp_nbits = 3 + p_opaque_nbits + c_line_len_nbits + p_line_nbits,
   localparam int c_word_req_nbits  = 3 + p_opaque_nbits + p_addr_nbits + c_word_len_nbits + p_word_nbits,
   localparam int c_word_resp_nbits = 3 + p_opaque_nbits + c_word_len_nbits + p_word_nbits
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         i_domain,
   input  logic                         i_line_req_val,
   output logic                         o_line_req_rdy,
   input  logic [c_line_req_nbits-1:0]  i_line_req_msg,
   output logic                         o_line_resp_val,
   input  logic                         i_line_resp_rdy,
   output logic [c_line_resp_nbits-1:0] o_line_resp_msg,
   output logic                         o_mem_domain,
   output logic                         o_memreq_val,
   input  logic                         i_memreq_rdy,
   output logic [c_word_req_nbits-1:0]  o_memreq_msg,
   input  logic                         i_memresp_val,
   output logic                         o_memresp_rdy,
`ifdef MEM_LINE_SERIALIZER_INSECURE_ZERO_EN
   input  logic                         i_memresp_insecure,
`endif
   input  logic [c_word_resp_nbits-1:0] i_memresp_msg
);

   localparam int c_nwords    = p_line_nbits / p_word_nbits;
   localparam int c_idx_nbits = $clog2(c_nwords);
   localparam int c_cnt_nbits = $clog2(c_nwords + 1);

   localparam logic [2:0] c_type_read  = 3'd0;
   localparam logic [2:0] c_type_write = 3'd1;

   localparam logic [c_cnt_nbits-1:0]  c_cnt_one  = c_cnt_nbits'(1);
   localparam logic [c_cnt_nbits-1:0]  c_cnt_last = c_cnt_nbits'(c_nwords - 1);
   localparam logic [p_addr_nbits-1:0] c_line_off = p_addr_nbits'(p_line_nbits / 8 - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                    r_state;
   logic [2:0]                r_type;
   logic [p_opaque_nbits-1:0] r_opaque;
   logic [p_addr_nbits-1:0]   r_addr;
   logic [p_line_nbits-1:0]   r_line;
   logic                      r_domain;
   logic [c_cnt_nbits-1:0]    r_req_cnt;
   logic [c_cnt_nbits-1:0]    r_resp_cnt;
   logic                      r_memreq_val;
   logic                      r_line_resp_val;
   logic                      r_insecure;

   // Line request fields
   logic [2:0]                  w_lreq_type;
   logic [p_opaque_nbits-1:0]   w_lreq_opaque;
   logic [p_addr_nbits-1:0]     w_lreq_addr;
   logic [c_line_len_nbits-1:0] w_lreq_len;
   logic [p_line_nbits-1:0]     w_lreq_data;

   assign {w_lreq_type, w_lreq_opaque, w_lreq_addr, w_lreq_len, w_lreq_data} = i_line_req_msg;

   // Word response fields
   logic [2:0]                  w_mresp_type;
   logic [p_opaque_nbits-1:0]   w_mresp_opaque;
   logic [c_word_len_nbits-1:0] w_mresp_len;
   logic [p_word_nbits-1:0]     w_mresp_data;

   assign {w_mresp_type, w_mresp_opaque, w_mresp_len, w_mresp_data} = i_memresp_msg;

   // Fields the serializer does not act on: lengths are implied and the
   // opaque echoed back to the cache is the latched one.
   logic w_unused;
   assign w_unused = ^{w_lreq_len, w_mresp_opaque, w_mresp_len};

   logic                    w_req_fire;
   logic                    w_resp_fire;
   logic                    w_resp_data_ok;
   logic                    w_resp_flag;
   logic [c_idx_nbits-1:0]  w_req_idx;
   logic [c_idx_nbits-1:0]  w_resp_idx;
   logic [p_addr_nbits-1:0] w_req_addr;
   logic [p_word_nbits-1:0] w_req_data;
   logic [p_line_nbits-1:0] w_resp_data;

   assign w_req_fire  = r_memreq_val & i_memreq_rdy;
   assign w_resp_fire = i_memresp_val & o_memresp_rdy;
   assign w_req_idx   = r_req_cnt[c_idx_nbits-1:0];
   assign w_resp_idx  = r_resp_cnt[c_idx_nbits-1:0];

   // Only read responses of the matching type carry data into the line buffer.
   assign w_resp_data_ok = (r_type == c_type_read) && (w_mresp_type == r_type);

   // Word address steps by one word per request from the aligned line base.
   assign w_req_addr = r_addr + (p_addr_nbits'(r_req_cnt) << c_word_len_nbits);

   // Word request data: the selected line slice for writes, zero otherwise
   always_comb begin
      // NOTE: assigning a default first gives every path a value, so no latch is inferred.
      w_req_data = '0;
      if (r_type == c_type_write) begin
         w_req_data = r_line[p_word_nbits*w_req_idx +: p_word_nbits];
      end
   end

`ifdef MEM_LINE_SERIALIZER_INSECURE_ZERO_EN
   assign w_resp_flag = i_memresp_insecure;
   assign w_resp_data = (r_type == c_type_read && !r_insecure) ? r_line : '0;
`else
   assign w_resp_flag = 1'b0;
   assign w_resp_data = (r_type == c_type_read) ? r_line : '0;
`endif

   assign o_line_req_rdy  = (r_state == IDLE);
   assign o_memreq_val    = r_memreq_val;
   assign o_line_resp_val = r_line_resp_val;
   assign o_mem_domain    = r_domain;

   // A response is taken only once its request has left, or as it leaves.
   assign o_memresp_rdy = (r_state == XFER) && ((r_resp_cnt < r_req_cnt) || w_req_fire);

   assign o_memreq_msg = {r_type, r_opaque, w_req_addr, c_word_len_nbits'(0), w_req_data};

   assign o_line_resp_msg = {r_type, r_opaque, c_line_len_nbits'(0), w_resp_data};

   // Control FSM with registered handshake outputs, line buffer and counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the line buffer is reset with the control state so a stale line
         // can never leak into a later response or into another security domain.
         r_state         <= IDLE;
         r_type          <= '0;
         r_opaque        <= '0;
         r_addr          <= '0;
         r_line          <= '0;
         r_domain        <= 1'b0;
         r_req_cnt       <= '0;
         r_resp_cnt      <= '0;
         r_memreq_val    <= 1'b0;
         r_line_resp_val <= 1'b0;
         r_insecure      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every register update from the
         // same pre-edge values, independent of statement order.
         case (r_state)
            IDLE: begin
               if (i_line_req_val) begin
                  r_type       <= w_lreq_type;
                  r_opaque     <= w_lreq_opaque;
                  r_addr       <= w_lreq_addr & ~c_line_off;
                  r_line       <= (w_lreq_type == c_type_write) ? w_lreq_data : '0;
                  r_domain     <= i_domain;
                  r_req_cnt    <= '0;
                  r_resp_cnt   <= '0;
                  r_insecure   <= 1'b0;
                  r_memreq_val <= 1'b1;
                  r_state      <= XFER;
               end
            end

            XFER: begin
               if (w_req_fire) begin
                  r_req_cnt    <= r_req_cnt + c_cnt_one;
                  r_memreq_val <= (r_req_cnt != c_cnt_last);
               end
               if (w_resp_fire) begin
                  r_resp_cnt <= r_resp_cnt + c_cnt_one;
                  if (w_resp_data_ok) begin
                     r_line[p_word_nbits*w_resp_idx +: p_word_nbits] <= w_mresp_data;
                  end
                  if (w_resp_flag) begin
                     r_insecure <= 1'b1;
                  end
                  if (r_resp_cnt == c_cnt_last) begin
                     r_line_resp_val <= 1'b1;
                     r_state         <= RESP;
                  end
               end
            end

            RESP: begin
               if (i_line_resp_rdy) begin
                  r_line_resp_val <= 1'b0;
                  r_domain        <= 1'b0;
                  r_state         <= IDLE;
               end
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
